// File: rtl/acc_seq_pkg.sv
// ---------------------------------------------------------------------------
// acc_seq_pkg
// Shared types for the accelerator job sequencer: the sequencer state enum,
// the result status codes reported to the host, and the 256-bit job
// descriptor that travels through the job FIFO.
// No ports (package).
// ---------------------------------------------------------------------------
package acc_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RST,
      RUN,
      RES
   } state_e;

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_BADLEN  = 2'd1,
      ST_TIMEOUT = 2'd2
   } status_e;

   typedef struct packed {
      logic [63:0] readBase;
      logic [63:0] writeBase;
      logic [63:0] numRead;
      logic [63:0] elemSize;
   } job_t;

   localparam int JOB_W = $bits(job_t);

   // A job whose element count is zero or larger than the wrapper buffer is
   // never handed to the accelerator.
   function automatic logic isBadLen(input logic [63:0] numRead, input int maxN);
      return (numRead == 64'd0) || (numRead > 64'(maxN));
   endfunction

endpackage

// File: rtl/job_fifo.sv
// ---------------------------------------------------------------------------
// job_fifo
// Synchronous FIFO holding pending job descriptors.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   i_wrEn, i_wrData    push request and data
//   i_rdEn              pop request (ignored when empty)
//   o_rdData            head entry (show-ahead)
//   o_full, o_empty     occupancy flags; o_full is a register
// ---------------------------------------------------------------------------
module job_fifo #(
   parameter int WIDTH = 256,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_wrEn,
   input  logic [WIDTH-1:0] i_wrData,
   input  logic             i_rdEn,
   output logic [WIDTH-1:0] o_rdData,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [AW:0]      r_count;
   logic [AW:0]      w_countNext;
   logic             r_full;
   logic             w_doWrite;
   logic             w_doRead;

   // A pop frees a slot in the same cycle, so a push alongside a pop is
   // accepted even when the FIFO is full.
   assign w_doRead  = i_rdEn && (r_count != '0);
   assign w_doWrite = i_wrEn && (!r_full || w_doRead);

   // Occupancy after this cycle's push/pop.
   always_comb begin
      w_countNext = r_count;
      if (w_doWrite && !w_doRead) begin
         w_countNext = r_count + (AW+1)'(1);
      end else if (!w_doWrite && w_doRead) begin
         w_countNext = r_count - (AW+1)'(1);
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; the full flag
   // is registered from the next occupancy so the ready output is glitch-free.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
      end else begin
         if (w_doWrite) begin
            r_wrPtr <= r_wrPtr + AW'(1);
         end
         if (w_doRead) begin
            r_rdPtr <= r_rdPtr + AW'(1);
         end
         r_count <= w_countNext;
         r_full  <= (w_countNext == FULL_COUNT);
      end
   end

   // Storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (w_doWrite) begin
         r_mem[r_wrPtr] <= i_wrData;
      end
   end

   assign o_rdData = r_mem[r_rdPtr];
   assign o_full   = r_full;
   assign o_empty  = (r_count == '0);

endmodule

// File: rtl/acc_job_sequencer.sv
// ---------------------------------------------------------------------------
// acc_job_sequencer
// Runs queued jobs one at a time through a single-shot accelerator wrapper:
// latches the job config, holds the wrapper in reset for RST_CYCLES, lets it
// run until done (or timeout) and returns a tagged result to the host.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   job_valid/job_ready/job_*       job descriptor push interface
//   acc_reset, acc_*                wrapper reset and latched job config
//   acc_done, acc_returnvalue       wrapper completion
//   res_valid/res_ready/res_*       result handshake (value, status, tag)
//   busy, jobs_done                 activity flag and accepted-result count
// ---------------------------------------------------------------------------
module acc_job_sequencer
   import acc_seq_pkg::*;
#(
   parameter int JOB_DEPTH  = 4,
   parameter int MAX_N      = 128,
   parameter int RST_CYCLES = 2,
   parameter int TIMEOUT    = 1000000,
   parameter int TAG_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             job_valid,
   output logic             job_ready,
   input  logic [63:0]      job_read_base,
   input  logic [63:0]      job_write_base,
   input  logic [63:0]      job_num_read,
   input  logic [63:0]      job_elem_size,
   output logic             acc_reset,
   output logic [63:0]      acc_read_base,
   output logic [63:0]      acc_write_base,
   output logic [63:0]      acc_num_read,
   output logic [63:0]      acc_read_size,
   input  logic             acc_done,
   input  logic [31:0]      acc_returnvalue,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_value,
   output logic [1:0]       res_status,
   output logic [TAG_W-1:0] res_tag,
   output logic             busy,
   output logic [31:0]      jobs_done
);

   localparam logic [31:0] RST_LAST     = 32'(RST_CYCLES - 1);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

   state_e           r_state;
   state_e           w_stateNext;
   job_t             r_cfg;
   job_t             w_head;
   job_t             w_pushJob;
   logic             w_fifoFull;
   logic             w_fifoEmpty;
   logic             w_push;
   logic             w_pop;
   logic             w_headBad;
   logic [31:0]      r_rstCtr;
   logic [31:0]      r_runTimer;
   logic [TAG_W-1:0] r_tagCtr;
   logic [31:0]      r_jobsDone;
   logic [31:0]      r_resValue;
   status_e          r_resStatus;
   logic [TAG_W-1:0] r_resTag;

   assign w_pushJob = '{readBase:  job_read_base,
                        writeBase: job_write_base,
                        numRead:   job_num_read,
                        elemSize:  job_elem_size};
   assign job_ready = !w_fifoFull;
   assign w_push    = job_valid && job_ready;
   assign w_headBad = isBadLen(w_head.numRead, MAX_N);

   job_fifo #(
      .WIDTH (JOB_W),
      .DEPTH (JOB_DEPTH)
   ) u_jobFifo (
      .clk      (clk),
      .reset    (reset),
      .i_wrEn   (w_push),
      .i_wrData (w_pushJob),
      .i_rdEn   (w_pop),
      .o_rdData (w_head),
      .o_full   (w_fifoFull),
      .o_empty  (w_fifoEmpty)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next state and FIFO pop. Only IDLE pops, so a job waiting behind an
   // unaccepted result stays queued. acc_done wins over a same-cycle timeout
   // because both just move to RES; the datapath picks the status.
   always_comb begin
      w_stateNext = r_state;
      w_pop       = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_fifoEmpty) begin
               w_pop       = 1'b1;
               w_stateNext = w_headBad ? RES : RST;
            end
         end
         RST: begin
            if (r_rstCtr == RST_LAST) begin
               w_stateNext = RUN;
            end
         end
         RUN: begin
            if (acc_done || (r_runTimer == TIMEOUT_LAST)) begin
               w_stateNext = RES;
            end
         end
         RES: begin
            if (res_ready) begin
               w_stateNext = IDLE;
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   // Datapath: config latch on pop, reset/run counters, result capture and
   // counters. The run timer is held at zero throughout RST so it starts
   // from zero on RUN entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cfg       <= '0;
         r_rstCtr    <= '0;
         r_runTimer  <= '0;
         r_tagCtr    <= '0;
         r_jobsDone  <= '0;
         r_resValue  <= '0;
         r_resStatus <= ST_OK;
         r_resTag    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_cfg    <= w_head;
                  r_resTag <= r_tagCtr;
                  r_tagCtr <= r_tagCtr + TAG_W'(1);
                  r_rstCtr <= '0;
                  if (w_headBad) begin
                     r_resStatus <= ST_BADLEN;
                     r_resValue  <= '0;
                  end
               end
            end
            RST: begin
               r_rstCtr   <= r_rstCtr + 32'd1;
               r_runTimer <= '0;
            end
            RUN: begin
               r_runTimer <= r_runTimer + 32'd1;
               if (acc_done) begin
                  r_resValue  <= acc_returnvalue;
                  r_resStatus <= ST_OK;
               end else if (r_runTimer == TIMEOUT_LAST) begin
                  r_resValue  <= '0;
                  r_resStatus <= ST_TIMEOUT;
               end
            end
            RES: begin
               if (res_ready) begin
                  r_jobsDone <= r_jobsDone + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // The wrapper is held in reset everywhere except RUN so every run starts
   // from a fresh wrapper.
   assign acc_reset      = (r_state != RUN);
   assign acc_read_base  = r_cfg.readBase;
   assign acc_write_base = r_cfg.writeBase;
   assign acc_num_read   = r_cfg.numRead;
   assign acc_read_size  = r_cfg.elemSize;
   assign res_valid      = (r_state == RES);
   assign res_value      = r_resValue;
   assign res_status     = r_resStatus;
   assign res_tag        = r_resTag;
   assign busy           = (r_state != IDLE) || !w_fifoEmpty;
   assign jobs_done      = r_jobsDone;

endmodule

// File: tb/tb_acc_job_sequencer.sv
// ---------------------------------------------------------------------------
// tb_acc_job_sequencer
// Self-checking bench for acc_job_sequencer. A behavioural wrapper model
// answers each run after wrapDelay RUN cycles; a queue-based reference model
// predicts value/status/tag of every job from its descriptor.
// ---------------------------------------------------------------------------
module tb_acc_job_sequencer;

   localparam int TAG_W = 8;
   localparam int TMO   = 100;
   localparam int MAXN  = 128;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             job_valid = 1'b0;
   logic             job_ready;
   logic [63:0]      job_read_base = '0;
   logic [63:0]      job_write_base = '0;
   logic [63:0]      job_num_read = '0;
   logic [63:0]      job_elem_size = '0;
   logic             acc_reset;
   logic [63:0]      acc_read_base;
   logic [63:0]      acc_write_base;
   logic [63:0]      acc_num_read;
   logic [63:0]      acc_read_size;
   logic             acc_done = 1'b0;
   logic [31:0]      acc_returnvalue = '0;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic [31:0]      res_value;
   logic [1:0]       res_status;
   logic [TAG_W-1:0] res_tag;
   logic             busy;
   logic [31:0]      jobs_done;

   typedef struct {
      logic [31:0] value;
      logic [1:0]  status;
      logic [7:0]  tag;
   } exp_t;

   exp_t expQ[$];
   int   total = 0;
   int   bad = 0;
   int   tagModel = 0;
   int   jobsModel = 0;
   int   runsExpected = 0;
   int   runsSeen = 0;
   int   wrapDelay = 50;
   int   runIdx = -1;
   logic prevAccReset = 1'b1;

   acc_job_sequencer #(
      .JOB_DEPTH  (4),
      .MAX_N      (MAXN),
      .RST_CYCLES (2),
      .TIMEOUT    (TMO),
      .TAG_W      (TAG_W)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .job_valid       (job_valid),
      .job_ready       (job_ready),
      .job_read_base   (job_read_base),
      .job_write_base  (job_write_base),
      .job_num_read    (job_num_read),
      .job_elem_size   (job_elem_size),
      .acc_reset       (acc_reset),
      .acc_read_base   (acc_read_base),
      .acc_write_base  (acc_write_base),
      .acc_num_read    (acc_num_read),
      .acc_read_size   (acc_read_size),
      .acc_done        (acc_done),
      .acc_returnvalue (acc_returnvalue),
      .res_valid       (res_valid),
      .res_ready       (res_ready),
      .res_value       (res_value),
      .res_status      (res_status),
      .res_tag         (res_tag),
      .busy            (busy),
      .jobs_done       (jobs_done)
   );

   always #5 clk = ~clk;

   // Wrapper model: counts cycles since its reset was released and pulses
   // done at cycle index wrapDelay (never when negative). The return value is
   // derived from the config it was given, garbage otherwise. Also counts
   // how many runs (acc_reset falling) the wrapper actually saw.
   always @(posedge clk) begin
      #2;
      if (acc_reset) runIdx = -1;
      else runIdx = runIdx + 1;
      acc_done = (runIdx >= 0) && (runIdx == wrapDelay);
      acc_returnvalue = acc_done ? (acc_write_base[31:0] - acc_read_base[31:0] + 32'hBAFE)
                                 : 32'hDEAD_BEEF;
      if (prevAccReset && !acc_reset) runsSeen = runsSeen + 1;
      prevAccReset = acc_reset;
   end

   // Watchdog so the bench can never hang.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: expected result of a job straight from its descriptor.
   function automatic exp_t predict(input logic [63:0] rb, input logic [63:0] wb, input logic [63:0] n);
      exp_t e;
      int   t;
      t = tagModel % 256;
      e.tag = t[7:0];
      if (n == 64'd0 || n > 64'(MAXN)) begin
         e.status = 2'd1;
         e.value  = '0;
      end else if (wrapDelay < 0 || wrapDelay >= TMO) begin
         e.status = 2'd2;
         e.value  = '0;
      end else begin
         e.status = 2'd0;
         e.value  = wb[31:0] - rb[31:0] + 32'hBAFE;
      end
      return e;
   endfunction

   // Offers one job and returns one cycle after it was accepted.
   task automatic applyStimulus(input logic [63:0] rb, input logic [63:0] wb,
                                input logic [63:0] n, input logic [63:0] es);
      int w;
      w = 0;
      job_read_base  = rb;
      job_write_base = wb;
      job_num_read   = n;
      job_elem_size  = es;
      job_valid      = 1'b1;
      while (!job_ready && w < 300) begin
         step();
         w++;
      end
      checkOutput("push job_ready", job_ready, 1);
      if (job_ready) begin
         step();
         expQ.push_back(predict(rb, wb, n));
         tagModel++;
      end
      job_valid = 1'b0;
   endtask

   // Waits for a result, checks it against the model and accepts it.
   task automatic collectResult(input string tag, input int budget);
      int   n;
      exp_t e;
      n = 0;
      while (!res_valid && n < budget) begin
         step();
         n++;
      end
      checkOutput({tag, " res_valid"}, res_valid, 1);
      if (res_valid) begin
         checkOutput({tag, " pending"}, 64'(expQ.size() != 0), 1);
         checkOutput({tag, " acc_reset in RES"}, acc_reset, 1);
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput({tag, " value"}, res_value, e.value);
            checkOutput({tag, " status"}, res_status, e.status);
            checkOutput({tag, " tag"}, res_tag, e.tag);
            if (e.status != 2'd1) runsExpected++;
         end
         res_ready = 1'b1;
         step();
         res_ready = 1'b0;
         jobsModel++;
         checkOutput({tag, " jobs_done"}, jobs_done, 32'(jobsModel));
      end
   endtask

   // From RUN entry, counts cycles until res_valid while watching config.
   task automatic runToResult(output int n, output bit stable);
      logic [63:0] rb, wb, nr, es;
      rb = acc_read_base;
      wb = acc_write_base;
      nr = acc_num_read;
      es = acc_read_size;
      n = 0;
      stable = 1'b1;
      while (!res_valid && n < 300) begin
         step();
         n++;
         if (!res_valid && (acc_read_base !== rb || acc_write_base !== wb ||
             acc_num_read !== nr || acc_read_size !== es || acc_reset !== 1'b0))
            stable = 1'b0;
      end
   endtask

   task automatic waitRun(input string tag);
      int w;
      w = 0;
      while (acc_reset && w < 50) begin
         step();
         w++;
      end
      checkOutput({tag, " run entered"}, acc_reset, 0);
   endtask

   initial begin
      int  lat;
      bit  stable;
      bit  held;
      logic [31:0] sv;
      logic [1:0]  ss;
      logic [7:0]  st;
      logic [63:0] sb;

      // ---- reset values ----
      reset = 1'b1;
      repeat (3) step();
      checkOutput("rst acc_reset", acc_reset, 1);
      checkOutput("rst res_valid", res_valid, 0);
      checkOutput("rst busy", busy, 0);
      checkOutput("rst jobs_done", jobs_done, 0);
      checkOutput("rst res_tag", res_tag, 0);
      checkOutput("rst res_value", res_value, 0);
      checkOutput("rst res_status", res_status, 0);
      checkOutput("rst acc_read_base", acc_read_base, 0);
      checkOutput("rst acc_num_read", acc_num_read, 0);
      reset = 1'b0;
      step();
      checkOutput("post-rst job_ready", job_ready, 1);

      // ---- single job, done 50 cycles into RUN ----
      wrapDelay = 50;
      applyStimulus(64'h1000, 64'h2000, 64'd16, 64'd4);
      checkOutput("t1 busy", busy, 1);
      checkOutput("t1 acc_reset idle", acc_reset, 1);
      step();
      checkOutput("t1 acc_reset rst0", acc_reset, 1);
      checkOutput("t1 read_base", acc_read_base, 64'h1000);
      checkOutput("t1 write_base", acc_write_base, 64'h2000);
      checkOutput("t1 num_read", acc_num_read, 64'd16);
      checkOutput("t1 read_size", acc_read_size, 64'd4);
      step();
      checkOutput("t1 acc_reset rst1", acc_reset, 1);
      step();
      checkOutput("t1 acc_reset run", acc_reset, 0);
      runToResult(lat, stable);
      checkOutput("t1 latency", 64'(lat), 51);
      checkOutput("t1 config stable", 64'(stable), 1);
      checkOutput("t1 value literal", res_value, 32'hCAFE);
      collectResult("t1", 5);

      // ---- five back-to-back jobs ----
      wrapDelay = int'($urandom_range(5, 30));
      for (int i = 0; i < 5; i++)
         applyStimulus({32'h0, $urandom}, {32'h0, $urandom},
                       64'($urandom_range(1, MAXN)), 64'd8);
      checkOutput("b2b job_ready full", job_ready, 0);
      for (int i = 0; i < 5; i++) collectResult("b2b", 400);
      checkOutput("b2b runs", 64'(runsSeen), 64'(runsExpected));

      // ---- BADLEN lengths then a valid job ----
      applyStimulus(64'h10, 64'h20, 64'd0, 64'd4);
      applyStimulus(64'h30, 64'h40, 64'd129, 64'd4);
      applyStimulus(64'h50, 64'h70, 64'd7, 64'd4);
      collectResult("badlen0", 50);
      collectResult("badlen129", 50);
      checkOutput("badlen no run", 64'(runsSeen), 64'(runsExpected));
      collectResult("after badlen", 400);

      // ---- timeout, then done exactly on the last RUN cycle ----
      wrapDelay = -1;
      applyStimulus(64'h100, 64'h900, 64'd32, 64'd4);
      waitRun("tmo");
      runToResult(lat, stable);
      checkOutput("tmo latency", 64'(lat), 100);
      collectResult("tmo", 5);
      wrapDelay = TMO - 1;
      applyStimulus(64'h200, 64'hA00, 64'd32, 64'd4);
      waitRun("edge");
      runToResult(lat, stable);
      checkOutput("edge latency", 64'(lat), 100);
      collectResult("edge", 5);

      // ---- result held with a job queued behind it ----
      wrapDelay = 10;
      applyStimulus(64'h300, 64'h800, 64'd3, 64'd2);
      applyStimulus(64'h400, 64'h500, 64'd5, 64'd2);
      lat = 0;
      while (!res_valid && lat < 300) begin
         step();
         lat++;
      end
      sv = res_value;
      ss = res_status;
      st = res_tag;
      sb = acc_read_base;
      held = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (res_valid !== 1'b1 || res_value !== sv || res_status !== ss ||
             res_tag !== st || acc_reset !== 1'b1 || acc_read_base !== sb || busy !== 1'b1)
            held = 1'b0;
      end
      checkOutput("hold stable", 64'(held), 1);
      collectResult("hold0", 5);
      collectResult("hold1", 300);

      // ---- randomized rounds ----
      for (int r = 0; r < 4; r++) begin
         wrapDelay = int'($urandom_range(1, TMO - 1));
         for (int j = 0; j < 3; j++) begin
            logic [63:0] n;
            case ($urandom_range(0, 5))
               0: n = 64'd0;
               1: n = 64'(MAXN + 1 + int'($urandom_range(0, 1000)));
               2: n = {$urandom | 32'h1, 32'h5};
               3: n = 64'(MAXN);
               default: n = 64'($urandom_range(1, MAXN));
            endcase
            applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, n, 64'($urandom_range(1, 16)));
         end
         for (int j = 0; j < 3; j++) collectResult("rand", 400);
      end
      checkOutput("rand runs", 64'(runsSeen), 64'(runsExpected));

      // ---- reset in the middle of a run with two jobs queued ----
      wrapDelay = 50;
      for (int i = 0; i < 3; i++)
         applyStimulus(64'h1000 * 64'(i + 1), 64'h7000, 64'd9, 64'd4);
      waitRun("midrst");
      repeat (5) step();
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midrst acc_reset", acc_reset, 1);
      checkOutput("midrst busy", busy, 0);
      checkOutput("midrst res_valid", res_valid, 0);
      checkOutput("midrst read_base", acc_read_base, 0);
      checkOutput("midrst job_ready", job_ready, 1);
      checkOutput("midrst res_tag", res_tag, 0);
      checkOutput("midrst jobs_done", jobs_done, 0);
      expQ.delete();
      tagModel = 0;
      jobsModel = 0;
      runsExpected++;
      repeat (2) step();
      reset = 1'b0;
      held = 1'b1;
      for (int i = 0; i < 80; i++) begin
         step();
         if (res_valid !== 1'b0 || busy !== 1'b0 || acc_reset !== 1'b1) held = 1'b0;
      end
      checkOutput("midrst quiet", 64'(held), 1);
      applyStimulus(64'h40, 64'h60, 64'd1, 64'd4);
      collectResult("post-rst job", 300);
      checkOutput("final runs", 64'(runsSeen), 64'(runsExpected));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
